gnn_0_example_save: RTL and testbench
=====================================

GNN_0_EXAMPLE_SAVE -- requirements
Module: gnn_0_example_save

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameters SHALL be:
- SAVE_INST_LENGTH, 96, instruction width.
- C_M_AXI_ADDR_WIDTH, 64, AXI address width.
- C_M_AXI_DATA_WIDTH, 512, beat width.
- C_XFER_SIZE_WIDTH, 32, internal beat-counter width.
- C_BUF_ADDR_WIDTH, 11, buffer address width.
REQ-003 Ports SHALL be:
- aclk  in  1  clock.
- areset  in  1  asynchronous active-low reset.
- kernel_clk  in  1  reserved, unused.
- kernel_rst  in  1  reserved, unused.
- ap_start  in  1  start request.
- ap_done  out  1  completion pulse.
- ctrl_addr_offset  in  64  DRAM byte base address.
- ctrl_instruction  in  96  instruction word.
- save_read_buffer_addr_valid  out  1  buffer read request.
- save_read_buffer_addr  out  11  buffer line address.
- save_read_buffer_data_valid  in  1  buffer read data qualifier.
- save_read_buffer_data  in  512  buffer read data.
- m_axi_awvalid  out  1  AXI write-address valid.
- m_axi_awready  in  1  AXI write-address ready.
- m_axi_awaddr  out  64  AXI write address.
- m_axi_awlen  out  8  AXI burst length.
- m_axi_wvalid  out  1  AXI write-data valid.
- m_axi_wready  in  1  AXI write-data ready.
- m_axi_wdata  out  512  AXI write data.
- m_axi_wstrb  out  64  AXI write strobes.
- m_axi_wlast  out  1  AXI last beat.
- m_axi_bvalid  in  1  AXI write-response valid.
- m_axi_bready  out  1  AXI write-response ready.
- data_tready  in  1  stream throttle.
- data_tvalid  out  1  stream valid, FIFO head valid.
- data_tdata  out  512  stream data, FIFO head.

Function
REQ-004 Instruction fields SHALL be [95:80] DRAM_SIZE, [79:64] DRAM_START, [63:48] BUFFER_SIZE and [47:32] BUFFER_START; [31:0] is ignored.
REQ-005 The beat count SHALL be N = min(BUFFER_SIZE, DRAM_SIZE); each beat is 64 bytes.
REQ-006 The state machine SHALL have the states IDLE, RUN, WAIT_B and DONE.
- IDLE with ap_start=1 latches the instruction and offset, then goes to RUN.
- In IDLE, ap_start is sampled as a level.
REQ-007 In RUN, buffer reads SHALL issue at addresses BUFFER_START+k mod 2048, for k=0..N-1, at most one read per cycle.
REQ-008 Reads SHALL issue only while (FIFO occupancy + outstanding reads) < 16; the block never drops returned data.
REQ-009 The block SHALL accept save_read_buffer_data_valid at any latency of 1 cycle or more, in order.
- Each valid cycle pushes save_read_buffer_data into a 16-deep FIFO.
REQ-010 The DRAM address of beat k SHALL be ctrl_addr_offset + DRAM_START*64 + k*64.
REQ-011 AW bursts SHALL be at most 16 beats, with m_axi_awlen = beats-1.
- A burst is shortened so that it never crosses a 4 KB boundary.
- awvalid is held with stable awaddr and awlen until awready.
REQ-012 m_axi_wdata SHALL be the FIFO head.
- m_axi_wstrb is all ones.
- m_axi_wlast is asserted on the final beat of each burst.
- A beat pops when m_axi_wvalid && m_axi_wready.
REQ-013 m_axi_bready SHALL be 1 in RUN and WAIT_B.
- RUN goes to WAIT_B when all N beats have been sent.
- WAIT_B goes to DONE when all B responses have been counted.
REQ-014 DONE SHALL assert ap_done for exactly one cycle, then go to IDLE.
REQ-015 When N=0, the block SHALL go straight to DONE with no buffer or AXI traffic; ap_done follows 2 cycles after start.
REQ-016 Simultaneous FIFO push and pop SHALL keep the occupancy unchanged.
REQ-017 ap_start while busy SHALL be ignored.

Reset
REQ-018 areset=0 SHALL asynchronously force:
- state IDLE;
- FIFO empty;
- counters 0;
- all valid outputs, ap_done and m_axi_bready to 0;
- address and data outputs to 0.
REQ-019 Reset in the middle of an operation SHALL abandon the transfer; no completion is reported.

Configuration
REQ-020 With SAVE_TREADY_GATE_EN defined, m_axi_wvalid SHALL equal FIFO-not-empty && data_tready.
REQ-021 Without SAVE_TREADY_GATE_EN, data_tready SHALL be ignored and m_axi_wvalid SHALL equal FIFO-not-empty.

Structure
REQ-022 Package gnn_0_save_pkg SHALL hold:
- the width constants;
- the instruction field offsets;
- the state enum;
- FIFO depth 16;
- the maximum burst length of 16.
REQ-023 The 16x512 synchronous FIFO SHALL be the sub-module gnn_0_save_fifo.

Verification
REQ-024 Basic transfer:
- Stimulus: offset 0, DRAM_START=0, BUFFER_START=0x433, BUFFER_SIZE=16, DRAM_SIZE=0x200, 4-cycle buffer latency, ready always high.
- Response: reads 0x433..0x442, one burst awaddr 0 awlen 15, 16 beats in order, wlast on beat 16, one ap_done pulse.
REQ-025 Throttled transfer:
- Stimulus: same as REQ-024, with random data_tready and the macro defined.
- Response: the same data order; no beat is sent while data_tready=0.
REQ-026 4 KB split:
- Stimulus: DRAM_START=60, BUFFER_SIZE=8.
- Response: bursts awaddr 0xF00 len 3, then 0x1000 len 3.
REQ-027 Zero-length instruction:
- Stimulus: BUFFER_SIZE=0.
- Response: no AW or read traffic; ap_done 2 cycles after start.
REQ-028 Address wrap:
- Stimulus: BUFFER_START=0x7FE, size 4.
- Response: reads 0x7FE, 0x7FF, 0x000, 0x001.
REQ-029 Reset mid-transfer:
- Stimulus: areset=0 after 5 beats.
- Response: all outputs 0, state IDLE, no ap_done.

Source files
------------

// File: rtl/gnn_0_save_pkg.sv
// Shared constants, instruction field offsets, FSM states and burst sizing for the save engine.
package gnn_0_save_pkg;

    localparam int unsigned SaveInstLength = 96;
    localparam int unsigned AxiAddrWidth   = 64;
    localparam int unsigned AxiDataWidth   = 512;
    localparam int unsigned XferSizeWidth  = 32;
    localparam int unsigned BufAddrWidth   = 11;

    localparam int unsigned DramSizeLsb  = 80;
    localparam int unsigned DramStartLsb = 64;
    localparam int unsigned BufSizeLsb   = 48;
    localparam int unsigned BufStartLsb  = 32;

    localparam int unsigned FifoDepth    = 16;
    localparam int unsigned FifoCntWidth = $clog2(FifoDepth) + 1;
    localparam int unsigned MaxBurst     = 16;

    typedef enum logic [1:0] {StIdle, StRun, StWaitB, StDone} save_state_e;

    // Beats in the burst starting at addr: capped by MaxBurst, the next 4 KB page and what is left.
    function automatic logic [4:0] burst_beats(input logic [63:0] addr,
                                               input logic [31:0] remaining);
        logic [6:0]  to_bound;
        logic [31:0] beats;
        to_bound = 7'd64 - {1'b0, addr[11:6]};
        beats    = MaxBurst;
        if ({25'd0, to_bound} < beats) beats = {25'd0, to_bound};
        if (remaining < beats) beats = remaining;
        return beats[4:0];
    endfunction

endpackage

// File: rtl/gnn_0_save_fifo.sv
// Synchronous FIFO holding buffer read data until it is written out on AXI.
module gnn_0_save_fifo
    import gnn_0_save_pkg::*;
#(
    parameter int unsigned WIDTH = AxiDataWidth,
    parameter int unsigned DEPTH = FifoDepth
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PtrW-1:0]  wr_ptr, rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PtrW'(1);
            if (pop)  rd_ptr <= rd_ptr + PtrW'(1);
            case ({push, pop})
                2'b10:   count <= count + ($clog2(DEPTH)+1)'(1);
                2'b01:   count <= count - ($clog2(DEPTH)+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/gnn_0_example_save.sv
// Save engine: streams buffer lines to DRAM over AXI4 write bursts.
// Define SAVE_TREADY_GATE_EN to throttle write beats with data_tready.
module gnn_0_example_save
    import gnn_0_save_pkg::*;
#(
    parameter int unsigned SAVE_INST_LENGTH   = SaveInstLength,
    parameter int unsigned C_M_AXI_ADDR_WIDTH = AxiAddrWidth,
    parameter int unsigned C_M_AXI_DATA_WIDTH = AxiDataWidth,
    parameter int unsigned C_XFER_SIZE_WIDTH  = XferSizeWidth,
    parameter int unsigned C_BUF_ADDR_WIDTH   = BufAddrWidth
) (
    input  logic                            aclk,
    input  logic                            areset,
    input  logic                            kernel_clk,
    input  logic                            kernel_rst,
    input  logic                            ap_start,
    output logic                            ap_done,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   ctrl_addr_offset,
    input  logic [SAVE_INST_LENGTH-1:0]     ctrl_instruction,
    output logic                            save_read_buffer_addr_valid,
    output logic [C_BUF_ADDR_WIDTH-1:0]     save_read_buffer_addr,
    input  logic                            save_read_buffer_data_valid,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   save_read_buffer_data,
    output logic                            m_axi_awvalid,
    input  logic                            m_axi_awready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]                      m_axi_awlen,
    output logic                            m_axi_wvalid,
    input  logic                            m_axi_wready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                            m_axi_wlast,
    input  logic                            m_axi_bvalid,
    output logic                            m_axi_bready,
    input  logic                            data_tready,
    output logic                            data_tvalid,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   data_tdata
);
    localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned XW = C_XFER_SIZE_WIDTH;
    localparam int unsigned BW = C_BUF_ADDR_WIDTH;

    save_state_e                  state;
    logic [XW-1:0]                n_beats, rd_cnt, aw_cnt, w_cnt, b_need, b_cnt;
    logic [BW-1:0]                buf_start;
    logic [AW-1:0]                base_addr, aw_addr_cur, w_addr_cur;
    logic [FifoCntWidth-1:0]      outstanding, fifo_cnt;
    logic [4:0]                   w_left, w_len, aw_beats;
    logic                         fifo_empty, run, rd_issue, push, pop, b_hs;
    logic [C_M_AXI_DATA_WIDTH-1:0] fifo_head;
    logic [15:0]                  f_dram_size, f_dram_start, f_buf_size, f_buf_start, f_min;
    logic                         unused_in;

    assign f_dram_size  = ctrl_instruction[DramSizeLsb  +: 16];
    assign f_dram_start = ctrl_instruction[DramStartLsb +: 16];
    assign f_buf_size   = ctrl_instruction[BufSizeLsb   +: 16];
    assign f_buf_start  = ctrl_instruction[BufStartLsb  +: 16];
    assign f_min        = (f_buf_size < f_dram_size) ? f_buf_size : f_dram_size;
    assign unused_in    = ^{kernel_clk, kernel_rst, ctrl_instruction[BufStartLsb-1:0],
                            f_buf_start[15:BW]};

    assign run         = (state == StRun);
    assign aw_addr_cur = base_addr + (AW'(aw_cnt) << 6);
    assign w_addr_cur  = base_addr + (AW'(w_cnt) << 6);
    assign aw_beats    = burst_beats(aw_addr_cur, n_beats - aw_cnt);
    // W side re-derives burst boundaries itself so it never waits on the AW channel.
    assign w_len       = (w_left != '0) ? w_left : burst_beats(w_addr_cur, n_beats - w_cnt);

    // Credit check: every issued read already owns a FIFO slot, so returned data is never dropped.
    assign rd_issue = run && (rd_cnt < n_beats) &&
                      (({1'b0, fifo_cnt} + {1'b0, outstanding}) < 6'(FifoDepth));
    assign push     = save_read_buffer_data_valid && (state != StIdle);
    assign pop      = m_axi_wvalid && m_axi_wready;
    assign b_hs     = m_axi_bvalid && m_axi_bready;

`ifdef SAVE_TREADY_GATE_EN
    assign m_axi_wvalid = !fifo_empty && data_tready;
`else
    logic unused_tready;
    assign unused_tready = data_tready;
    assign m_axi_wvalid  = !fifo_empty;
`endif

    assign m_axi_wlast  = !fifo_empty && (w_len == 5'd1);
    assign m_axi_wdata  = fifo_empty ? '0 : fifo_head;
    assign m_axi_wstrb  = {(C_M_AXI_DATA_WIDTH/8){!fifo_empty}};
    assign m_axi_bready = (state == StRun) || (state == StWaitB);
    assign data_tvalid  = !fifo_empty;
    assign data_tdata   = m_axi_wdata;

    gnn_0_save_fifo #(
        .WIDTH (C_M_AXI_DATA_WIDTH),
        .DEPTH (FifoDepth)
    ) u_fifo (
        .clk   (aclk),
        .rst_n (areset),
        .push  (push),
        .din   (save_read_buffer_data),
        .pop   (pop),
        .head  (fifo_head),
        .count (fifo_cnt),
        .empty (fifo_empty)
    );

    always_ff @(posedge aclk or negedge areset) begin
        if (!areset) begin
            state                       <= StIdle;
            n_beats                     <= '0;
            rd_cnt                      <= '0;
            aw_cnt                      <= '0;
            w_cnt                       <= '0;
            b_need                      <= '0;
            b_cnt                       <= '0;
            buf_start                   <= '0;
            base_addr                   <= '0;
            outstanding                 <= '0;
            w_left                      <= '0;
            save_read_buffer_addr_valid <= 1'b0;
            save_read_buffer_addr       <= '0;
            m_axi_awvalid               <= 1'b0;
            m_axi_awaddr                <= '0;
            m_axi_awlen                 <= '0;
            ap_done                     <= 1'b0;
        end else begin
            ap_done                     <= 1'b0;
            save_read_buffer_addr_valid <= rd_issue;
            outstanding <= outstanding + FifoCntWidth'(rd_issue)
                           - FifoCntWidth'(push && (outstanding != '0));
            if (rd_issue) begin
                save_read_buffer_addr <= buf_start + rd_cnt[BW-1:0];
                rd_cnt                <= rd_cnt + XW'(1);
            end
            if (pop) begin
                w_cnt  <= w_cnt + XW'(1);
                w_left <= w_len - 5'd1;
            end
            if (b_hs) b_cnt <= b_cnt + XW'(1);
            if (m_axi_awvalid) begin
                if (m_axi_awready) m_axi_awvalid <= 1'b0;
            end else if (run && (aw_cnt < n_beats)) begin
                m_axi_awvalid <= 1'b1;
                m_axi_awaddr  <= aw_addr_cur;
                m_axi_awlen   <= {3'b000, aw_beats - 5'd1};
                aw_cnt        <= aw_cnt + XW'(aw_beats);
                b_need        <= b_need + XW'(1);
            end
            case (state)
                StIdle: if (ap_start) begin
                    n_beats   <= XW'(f_min);
                    buf_start <= f_buf_start[BW-1:0];
                    base_addr <= ctrl_addr_offset + (AW'(f_dram_start) << 6);
                    rd_cnt    <= '0;
                    aw_cnt    <= '0;
                    w_cnt     <= '0;
                    b_cnt     <= '0;
                    b_need    <= '0;
                    w_left    <= '0;
                    state     <= (f_min == '0) ? StDone : StRun;
                end
                StRun:   if (w_cnt == n_beats) state <= StWaitB;
                StWaitB: if (!m_axi_awvalid && (aw_cnt == n_beats) && (b_cnt == b_need)) begin
                    state <= StDone;
                end
                StDone: begin
                    ap_done <= 1'b1;
                    state   <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_gnn_0_example_save.sv
// Self-checking bench for gnn_0_example_save: directed and random transfers against a reference model.
module tb_gnn_0_example_save;

    logic         aclk = 1'b0, areset = 1'b0, kernel_clk = 1'b0, kernel_rst = 1'b0;
    logic         ap_start = 1'b0, ap_done;
    logic [63:0]  ctrl_addr_offset = '0;
    logic [95:0]  ctrl_instruction = '0;
    logic         save_read_buffer_addr_valid;
    logic [10:0]  save_read_buffer_addr;
    logic         save_read_buffer_data_valid = 1'b0;
    logic [511:0] save_read_buffer_data = '0;
    logic         m_axi_awvalid, m_axi_awready = 1'b1;
    logic [63:0]  m_axi_awaddr;
    logic [7:0]   m_axi_awlen;
    logic         m_axi_wvalid, m_axi_wready = 1'b1, m_axi_wlast;
    logic [511:0] m_axi_wdata;
    logic [63:0]  m_axi_wstrb;
    logic         m_axi_bvalid = 1'b0, m_axi_bready;
    logic         data_tready = 1'b1, data_tvalid;
    logic [511:0] data_tdata;

    gnn_0_example_save dut (
        .aclk                        (aclk),
        .areset                      (areset),
        .kernel_clk                  (kernel_clk),
        .kernel_rst                  (kernel_rst),
        .ap_start                    (ap_start),
        .ap_done                     (ap_done),
        .ctrl_addr_offset            (ctrl_addr_offset),
        .ctrl_instruction            (ctrl_instruction),
        .save_read_buffer_addr_valid (save_read_buffer_addr_valid),
        .save_read_buffer_addr       (save_read_buffer_addr),
        .save_read_buffer_data_valid (save_read_buffer_data_valid),
        .save_read_buffer_data       (save_read_buffer_data),
        .m_axi_awvalid               (m_axi_awvalid),
        .m_axi_awready               (m_axi_awready),
        .m_axi_awaddr                (m_axi_awaddr),
        .m_axi_awlen                 (m_axi_awlen),
        .m_axi_wvalid                (m_axi_wvalid),
        .m_axi_wready                (m_axi_wready),
        .m_axi_wdata                 (m_axi_wdata),
        .m_axi_wstrb                 (m_axi_wstrb),
        .m_axi_wlast                 (m_axi_wlast),
        .m_axi_bvalid                (m_axi_bvalid),
        .m_axi_bready                (m_axi_bready),
        .data_tready                 (data_tready),
        .data_tvalid                 (data_tvalid),
        .data_tdata                  (data_tdata)
    );

    always #5 aclk = ~aclk;

    logic [511:0] buf_mem [2048];
    int  n_cmp = 0, n_bad = 0, cyc = 0, done_cnt = 0, pending_b = 0, last_due = 0, due_v;
    int  lat_fixed = 4, strb_bad = 0;
    bit  rnd_rdy = 0, rnd_tready = 0, b_fire = 0;
    int           due_q[$];
    logic [10:0]  raddr_q[$];
    logic [10:0]  rd_log[$];
    logic [63:0]  awa_log[$];
    logic [7:0]   awl_log[$];
    logic [511:0] wd_log[$];
    bit           wl_log[$];
    bit           wt_log[$];

    // Buffer responder and AXI slave; handshakes are logged for the posedge that follows.
    always @(negedge aclk) begin
        cyc++;
        if (!areset) begin
            due_q.delete();
            raddr_q.delete();
            pending_b = 0;
            b_fire = 0;
            last_due = 0;
            save_read_buffer_data_valid = 1'b0;
            m_axi_bvalid = 1'b0;
        end else begin
            if (save_read_buffer_addr_valid) begin
                due_v = cyc - 1 + ((lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 6)));
                if (due_v <= last_due) due_v = last_due + 1;
                last_due = due_v;
                due_q.push_back(due_v);
                raddr_q.push_back(save_read_buffer_addr);
                rd_log.push_back(save_read_buffer_addr);
            end
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                save_read_buffer_data_valid = 1'b1;
                save_read_buffer_data = buf_mem[raddr_q[0]];
                void'(due_q.pop_front());
                void'(raddr_q.pop_front());
            end else begin
                save_read_buffer_data_valid = 1'b0;
            end
            if (b_fire) pending_b--;
            m_axi_bvalid = (pending_b > 0);
        end
        data_tready   = rnd_tready ? 1'($urandom_range(0, 1)) : 1'b1;
        m_axi_awready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        m_axi_wready  = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        if (m_axi_awvalid && m_axi_awready) begin
            awa_log.push_back(m_axi_awaddr);
            awl_log.push_back(m_axi_awlen);
        end
        if (m_axi_wvalid && m_axi_wready) begin
            wd_log.push_back(m_axi_wdata);
            wl_log.push_back(m_axi_wlast);
            wt_log.push_back(data_tready);
            if (m_axi_wstrb != '1) strb_bad++;
            if (m_axi_wlast) pending_b++;
        end
        b_fire = m_axi_bvalid && m_axi_bready;
        if (ap_done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        chk(tag, 512'(obs), 512'(exp));
    endtask

    task automatic chk_zero(input string tag);
        chk_int({tag, ":rd_valid"}, int'(save_read_buffer_addr_valid), 0);
        chk_int({tag, ":rd_addr"}, int'(save_read_buffer_addr), 0);
        chk_int({tag, ":awvalid"}, int'(m_axi_awvalid), 0);
        chk(    {tag, ":awaddr"}, 512'(m_axi_awaddr), '0);
        chk_int({tag, ":awlen"}, int'(m_axi_awlen), 0);
        chk_int({tag, ":wvalid"}, int'(m_axi_wvalid), 0);
        chk(    {tag, ":wdata"}, m_axi_wdata, '0);
        chk_int({tag, ":wlast"}, int'(m_axi_wlast), 0);
        chk_int({tag, ":bready"}, int'(m_axi_bready), 0);
        chk_int({tag, ":ap_done"}, int'(ap_done), 0);
        chk_int({tag, ":tvalid"}, int'(data_tvalid), 0);
        chk(    {tag, ":tdata"}, data_tdata, '0);
        chk(    {tag, ":wstrb"}, 512'(m_axi_wstrb), '0);
    endtask

    task automatic clear_logs();
        rd_log.delete(); awa_log.delete(); awl_log.delete();
        wd_log.delete(); wl_log.delete(); wt_log.delete();
        strb_bad = 0;
    endtask

    task automatic pulse_start(input logic [63:0] off, input int dsz, input int dst,
                               input int bsz, input int bst);
        ctrl_addr_offset = off;
        ctrl_instruction = {16'(dsz), 16'(dst), 16'(bsz), 16'(bst), 32'($urandom)};
        @(negedge aclk);
        ap_start = 1'b1;
        @(negedge aclk);
        ap_start = 1'b0;
    endtask

    // Reference: N = min sizes, reads wrap mod 2048, bursts of <=16 beats never crossing 4 KB.
    task automatic run_xfer(input string name, input logic [63:0] off, input int dsz,
                            input int dst, input int bsz, input int bst);
        logic [10:0]  exp_rd[$];
        logic [63:0]  exp_awa[$];
        logic [7:0]   exp_awl[$];
        logic [511:0] exp_wd[$];
        bit           exp_wl[$];
        logic [63:0]  addr;
        int n, rem, len, d0;
        n = (bsz < dsz) ? bsz : dsz;
        for (int k = 0; k < n; k++) begin
            exp_rd.push_back(11'((bst + k) % 2048));
            exp_wd.push_back(buf_mem[(bst + k) % 2048]);
        end
        addr = off + (64'(dst) << 6);
        rem  = n;
        while (rem > 0) begin
            len = (4096 - int'(addr[11:0])) / 64;
            if (len > 16) len = 16;
            if (len > rem) len = rem;
            exp_awa.push_back(addr);
            exp_awl.push_back(8'(len - 1));
            for (int j = 0; j < len; j++) exp_wl.push_back(j == len - 1);
            addr = addr + 64'(len * 64);
            rem  = rem - len;
        end
        clear_logs();
        d0 = done_cnt;
        pulse_start(off, dsz, dst, bsz, bst);
        for (int i = 0; i < 4000 && done_cnt == d0; i++) @(negedge aclk);
        repeat (5) @(negedge aclk);
        chk_int({name, ":done_pulses"}, done_cnt - d0, 1);
        chk_int({name, ":rd_count"}, rd_log.size(), exp_rd.size());
        for (int k = 0; k < exp_rd.size() && k < rd_log.size(); k++)
            chk_int($sformatf("%s:rd_addr[%0d]", name, k), int'(rd_log[k]), int'(exp_rd[k]));
        chk_int({name, ":aw_count"}, awa_log.size(), exp_awa.size());
        for (int k = 0; k < exp_awa.size() && k < awa_log.size(); k++) begin
            chk($sformatf("%s:awaddr[%0d]", name, k), 512'(awa_log[k]), 512'(exp_awa[k]));
            chk_int($sformatf("%s:awlen[%0d]", name, k), int'(awl_log[k]), int'(exp_awl[k]));
        end
        chk_int({name, ":beat_count"}, wd_log.size(), exp_wd.size());
        for (int k = 0; k < exp_wd.size() && k < wd_log.size(); k++) begin
            chk($sformatf("%s:wdata[%0d]", name, k), wd_log[k], exp_wd[k]);
            chk_int($sformatf("%s:wlast[%0d]", name, k), int'(wl_log[k]), int'(exp_wl[k]));
        end
        chk_int({name, ":wstrb_bad"}, strb_bad, 0);
        chk_int({name, ":idle_wvalid"}, int'(m_axi_wvalid), 0);
    endtask

    initial begin
        logic [10:0] wrap_exp [4];
        int d0, rd0, to_cnt, beats_low;
        wrap_exp = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};
        for (int i = 0; i < 2048; i++)
            for (int w = 0; w < 16; w++) buf_mem[i][w*32 +: 32] = $urandom;

        repeat (3) @(negedge aclk);
        chk_zero("reset");
        areset = 1'b1;
        repeat (2) @(negedge aclk);

        run_xfer("basic", 64'h0, 'h200, 0, 16, 'h433);
        chk_int("basic:awlen15", int'(awl_log.size() > 0 ? awl_log[0] : 8'hFF), 15);
        chk_int("basic:wlast16", int'(wl_log.size() == 16 ? wl_log[15] : 1'b0), 1);

        rnd_tready = 1; rnd_rdy = 1;
        run_xfer("throttle", 64'h0, 'h200, 0, 16, 'h433);
        beats_low = 0;
        foreach (wt_log[k]) if (!wt_log[k]) beats_low++;
`ifdef SAVE_TREADY_GATE_EN
        chk_int("throttle:beat_while_tready_low", beats_low, 0);
`endif
        rnd_tready = 0; rnd_rdy = 0;

        run_xfer("split", 64'h0, 'h200, 60, 8, 'h10);
        chk("split:aw0", 512'(awa_log.size() > 1 ? awa_log[0] : '1), 512'(64'hF00));
        chk("split:aw1", 512'(awa_log.size() > 1 ? awa_log[1] : '1), 512'(64'h1000));

        clear_logs();
        d0 = done_cnt;
        pulse_start(64'h40, 'h200, 5, 0, 'h100);
        chk_int("zero:done_c1", int'(ap_done), 0);
        @(negedge aclk);
        chk_int("zero:done_c2", int'(ap_done), 1);
        @(negedge aclk);
        chk_int("zero:done_c3", int'(ap_done), 0);
        repeat (10) @(negedge aclk);
        chk_int("zero:reads", rd_log.size(), 0);
        chk_int("zero:aw", awa_log.size(), 0);
        chk_int("zero:beats", wd_log.size(), 0);
        chk_int("zero:pulses", done_cnt - d0, 1);

        lat_fixed = 1;
        run_xfer("wrap", 64'h1000, 'h200, 3, 4, 'h7FE);
        for (int k = 0; k < 4; k++)
            chk_int($sformatf("wrap:rd[%0d]", k), int'(rd_log.size() > k ? rd_log[k] : 11'h3FF),
                    int'(wrap_exp[k]));

        lat_fixed = 0; rnd_rdy = 1; rnd_tready = 1;
        for (int t = 0; t < 6; t++)
            run_xfer($sformatf("rand%0d", t), {$urandom, $urandom} & ~64'h3F,
                     int'($urandom_range(0, 40)), int'($urandom_range(0, 65535)),
                     int'($urandom_range(1, 40)), int'($urandom_range(0, 2047)));

        lat_fixed = 2;
        clear_logs();
        d0 = done_cnt;
        pulse_start(64'h0, 32, 0, 32, 'h20);
        to_cnt = 0;
        while (wd_log.size() < 5 && to_cnt < 2000) begin
            @(negedge aclk);
            to_cnt++;
        end
        chk_int("midrst:reached_5_beats", int'(wd_log.size() >= 5), 1);
        #2 areset = 1'b0;
        #1 chk_zero("midrst");
        repeat (3) @(negedge aclk);
        areset = 1'b1;
        rd0 = rd_log.size();
        repeat (40) @(negedge aclk);
        chk_int("midrst:no_done", done_cnt - d0, 0);
        chk_int("midrst:no_reads", rd_log.size() - rd0, 0);
        chk_int("midrst:awvalid", int'(m_axi_awvalid), 0);
        chk_int("midrst:bready_idle", int'(m_axi_bready), 0);

        lat_fixed = 4; rnd_rdy = 0; rnd_tready = 0;
        run_xfer("recover", 64'h0, 'h200, 0, 16, 'h433);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: observed no finish, expected finish before 900000");
        $fatal(1, "bench timeout");
    end

endmodule
